load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/lsu_pkg.sv | 34 +++
 rtl/lsu_align.sv | 44 ++++
 rtl/load_store_unit.sv | 152 +++++++++++++++
 tb/tb_load_store_unit.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit: FSM states, funct3 access codes
// and access-size decode.
package lsu_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StIssue0,
    StWait0,
    StIssue1,
    StWait1,
    StDone
  } lsu_state_e;

  localparam logic [2:0] TYPE_B  = 3'b000;
  localparam logic [2:0] TYPE_H  = 3'b001;
  localparam logic [2:0] TYPE_W  = 3'b010;
  localparam logic [2:0] TYPE_BU = 3'b100;
  localparam logic [2:0] TYPE_HU = 3'b101;

  // Access size in bytes; illegal codes decode as 1 but never issue a beat.
  function automatic logic [2:0] access_size(input logic [2:0] t);
    case (t)
      TYPE_H, TYPE_HU: access_size = 3'd2;
      TYPE_W:          access_size = 3'd4;
      default:         access_size = 3'd1;
    endcase
  endfunction

  function automatic logic type_legal(input logic [2:0] t);
    type_legal = (t == TYPE_B) || (t == TYPE_H) || (t == TYPE_W) ||
                 (t == TYPE_BU) || (t == TYPE_HU);
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for the load/store unit: lane enables over two beats, store-data
// rotation and load merge with sign/zero extension.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  type_i,
  input  logic [1:0]  boff_i,
  input  logic [31:0] store_data_i,
  input  logic [31:0] rdata_lo_i,
  input  logic [31:0] rdata_hi_i,
  output logic [7:0]  lanes_o,
  output logic [31:0] wdata_o,
  output logic [31:0] load_data_o
);

  logic [2:0]  size;
  logic [7:0]  mask;
  logic [63:0] rot;
  logic [63:0] merged;

  always_comb begin
    size = access_size(type_i);
    case (size)
      3'd2:    mask = 8'h03;
      3'd4:    mask = 8'h0F;
      default: mask = 8'h01;
    endcase
    lanes_o = mask << boff_i;

    // Upper half of the doubled word shifted left is a rotate-left.
    rot     = {store_data_i, store_data_i} << {boff_i, 3'b000};
    wdata_o = rot[63:32];

    merged = {rdata_hi_i, rdata_lo_i} >> {boff_i, 3'b000};
    case (type_i)
      TYPE_B:  load_data_o = {{24{merged[7]}}, merged[7:0]};
      TYPE_BU: load_data_o = {24'h000000, merged[7:0]};
      TYPE_H:  load_data_o = {{16{merged[15]}}, merged[15:0]};
      TYPE_HU: load_data_o = {16'h0000, merged[15:0]};
      default: load_data_o = merged[31:0];
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// MEM-stage load/store unit: splits misaligned accesses into two word beats on a
// ready/valid memory port and stalls the pipeline until the access completes.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  input  logic              store,
  input  logic [ADDR_W-1:0] direccion,
  input  logic [ADDR_W-1:0] offset,
  input  logic [31:0]       store_data,
  input  logic [2:0]        Type,
  output logic              stall,
  output logic              load_valid,
  output logic [31:0]       load_data,
  output logic              err,
  output logic              m_req,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [3:0]        m_be,
  output logic [31:0]       m_wdata,
  input  logic              m_ready,
  input  logic              m_rvalid,
  input  logic [31:0]       m_rdata
);

  lsu_state_e        state_q, state_d;
  logic              store_q, split_q, illegal_q;
  logic [2:0]        type_q;
  logic [1:0]        boff_q;
  logic [ADDR_W-1:0] word_q;
  logic [31:0]       sdata_q, beat0_q, load_data_q;

  logic              latch_en, beat0_en, ld_update, ld_clear;
  logic [ADDR_W-1:0] ea;
  logic [3:0]        span;
  logic [7:0]        lanes;
  logic [31:0]       wdata, rdata_lo, rdata_hi, merged_load;
  logic              issue0, issue1;

  assign ea   = direccion + offset;
  assign span = {2'b00, ea[1:0]} + {1'b0, access_size(Type)};

  always_comb begin
    state_d   = state_q;
    latch_en  = 1'b0;
    beat0_en  = 1'b0;
    ld_update = 1'b0;
    ld_clear  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          latch_en = 1'b1;
          if (type_legal(Type)) begin
            state_d = StIssue0;
          end else begin
            state_d  = StDone;
            ld_clear = 1'b1;
          end
        end
      end
      StIssue0: if (m_ready) state_d = store_q ? (split_q ? StIssue1 : StDone) : StWait0;
      StWait0: begin
        if (m_rvalid) begin
          if (split_q) begin
            beat0_en = 1'b1;
            state_d  = StIssue1;
          end else begin
            ld_update = 1'b1;
            state_d   = StDone;
          end
        end
      end
      StIssue1: if (m_ready) state_d = store_q ? StDone : StWait1;
      StWait1: begin
        if (m_rvalid) begin
          ld_update = 1'b1;
          state_d   = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // The final beat's data comes straight off the bus so DONE can present the result.
  assign rdata_lo = (state_q == StWait0) ? m_rdata : beat0_q;
  assign rdata_hi = (state_q == StWait1) ? m_rdata : 32'h0;

  lsu_align u_align (
    .type_i       (type_q),
    .boff_i       (boff_q),
    .store_data_i (sdata_q),
    .rdata_lo_i   (rdata_lo),
    .rdata_hi_i   (rdata_hi),
    .lanes_o      (lanes),
    .wdata_o      (wdata),
    .load_data_o  (merged_load)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      store_q     <= 1'b0;
      split_q     <= 1'b0;
      illegal_q   <= 1'b0;
      type_q      <= 3'b000;
      boff_q      <= 2'b00;
      word_q      <= '0;
      sdata_q     <= 32'h0;
      beat0_q     <= 32'h0;
      load_data_q <= 32'h0;
    end else begin
      state_q <= state_d;
      if (latch_en) begin
        store_q   <= store;
        split_q   <= (span > 4'd4);
        illegal_q <= !type_legal(Type);
        type_q    <= Type;
        boff_q    <= ea[1:0];
        word_q    <= {ea[ADDR_W-1:2], 2'b00};
        sdata_q   <= store_data;
      end
      if (beat0_en) beat0_q <= m_rdata;
      if (ld_update) begin
        load_data_q <= merged_load;
      end else if (ld_clear) begin
        load_data_q <= 32'h0;
      end
    end
  end

  always_comb begin
    issue0     = (state_q == StIssue0);
    issue1     = (state_q == StIssue1);
    m_req      = issue0 || issue1;
    m_we       = m_req && store_q;
    m_addr     = issue0 ? word_q : (issue1 ? word_q + ADDR_W'(4) : '0);
    m_be       = issue0 ? lanes[3:0] : (issue1 ? lanes[7:4] : 4'b0000);
    m_wdata    = m_req ? wdata : 32'h0;
    // Gated by rst_n so a held req_valid cannot raise stall while in reset.
    stall      = rst_n && ((state_q != StIdle && state_q != StDone) ||
                           (state_q == StIdle && req_valid));
    load_valid = (state_q == StDone) && !store_q && !illegal_q;
    err        = (state_q == StDone) && illegal_q;
    load_data  = load_data_q;
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized bench for load_store_unit: a byte-addressed memory responder behind the DUT
// and a byte-level reference model of loads and stores.
module tb_load_store_unit;

  logic        clk, rst_n, req_valid, store;
  logic [31:0] direccion, offset, store_data;
  logic [2:0]  Type;
  logic        stall, load_valid, err, m_req, m_we, m_ready, m_rvalid;
  logic [31:0] load_data, m_addr, m_wdata, m_rdata;
  logic [3:0]  m_be;

  load_store_unit #(.ADDR_W(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .store      (store),
    .direccion  (direccion),
    .offset     (offset),
    .store_data (store_data),
    .Type       (Type),
    .stall      (stall),
    .load_valid (load_valid),
    .load_data  (load_data),
    .err        (err),
    .m_req      (m_req),
    .m_we       (m_we),
    .m_addr     (m_addr),
    .m_be       (m_be),
    .m_wdata    (m_wdata),
    .m_ready    (m_ready),
    .m_rvalid   (m_rvalid),
    .m_rdata    (m_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  task automatic check_eq(input string tag, input logic [95:0] got, input logic [95:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Memory as seen by the DUT (mem) and as predicted by the model (exp_mem).
  logic [7:0] mem     [logic [31:0]];
  logic [7:0] exp_mem [logic [31:0]];

  function automatic logic [7:0] init_byte(input logic [31:0] a);
    return 8'(a[7:0] * 8'd29 + a[15:8] + 8'd7);
  endfunction
  function automatic logic [7:0] mem_rd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : init_byte(a);
  endfunction
  function automatic logic [7:0] exp_rd(input logic [31:0] a);
    return exp_mem.exists(a) ? exp_mem[a] : init_byte(a);
  endfunction
  task automatic poke_word(input logic [31:0] a, input logic [31:0] w);
    for (int i = 0; i < 4; i++) begin
      mem[a + 32'(i)]     = w[8*i +: 8];
      exp_mem[a + 32'(i)] = w[8*i +: 8];
    end
  endtask

  function automatic int size_of(input logic [2:0] t);
    case (t)
      3'b000, 3'b100: return 1;
      3'b001, 3'b101: return 2;
      default:        return 4;
    endcase
  endfunction
  function automatic bit is_legal(input logic [2:0] t);
    return t inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
  endfunction
  function automatic logic [31:0] model_load(input logic [31:0] ea, input logic [2:0] t);
    int          sz = size_of(t);
    logic [31:0] v  = 32'h0;
    for (int i = 0; i < sz; i++) v[8*i +: 8] = exp_rd(ea + 32'(i));
    if (!t[2] && v[8*sz-1]) for (int i = 8 * sz; i < 32; i++) v[i] = 1'b1;
    return v;
  endfunction

  // Responder controls and beat log.
  int          ready_pct = 100, rv_delay_max = 0, hold_ready = 0;
  bit          resp_off = 0, force_rv = 0, spur_en = 0;
  bit          rd_pending = 0, rv_last = 0, prev_wait = 0;
  int          rd_delay = 0;
  logic [31:0] rd_addr;
  logic [68:0] prev_payload;
  logic [31:0] log_addr[$], log_wd[$];
  logic [3:0]  log_be[$];

  initial begin
    m_ready = 1'b0; m_rvalid = 1'b0; m_rdata = 32'h0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        rd_pending = 0; rv_last = 0; prev_wait = 0;
        m_rvalid = 1'b0; m_ready = 1'b0;
      end else begin
        if (rv_last) rd_pending = 0;
        rv_last  = 0;
        m_rvalid = 1'b0;
        if (force_rv) begin
          m_rvalid = 1'b1; m_rdata = $urandom;
        end else if (rd_pending && !resp_off) begin
          if (rd_delay == 0) begin
            m_rvalid = 1'b1;
            m_rdata  = {mem_rd(rd_addr + 3), mem_rd(rd_addr + 2), mem_rd(rd_addr + 1),
                        mem_rd(rd_addr)};
            rv_last  = 1;
          end else rd_delay--;
        end else if (!rd_pending && !m_req && spur_en && $urandom_range(3) == 0) begin
          m_rvalid = 1'b1; m_rdata = $urandom;
        end
        if (prev_wait && m_req) check_eq("payload_hold", {m_we, m_addr, m_be, m_wdata},
                                         prev_payload);
        if (hold_ready > 0 && m_req) begin
          m_ready = 1'b0; hold_ready--;
        end else m_ready = ($urandom_range(99) < ready_pct);
        if (m_req && m_ready) begin
          log_addr.push_back(m_addr); log_be.push_back(m_be); log_wd.push_back(m_wdata);
          if (m_we) begin
            for (int b = 0; b < 4; b++) if (m_be[b]) mem[m_addr + 32'(b)] = m_wdata[8*b +: 8];
          end else begin
            rd_pending = 1; rd_addr = m_addr; rd_delay = $urandom_range(rv_delay_max);
          end
          prev_wait = 0;
        end else begin
          prev_wait    = m_req;
          prev_payload = {m_we, m_addr, m_be, m_wdata};
        end
      end
    end
  end

  logic [31:0] exp_ld = 32'h0;

  task automatic run_txn(input bit st, input logic [31:0] dir, input logic [31:0] off,
                         input logic [31:0] sd, input logic [2:0] t, output int stalls);
    logic [31:0] ea = dir + off;
    int          sz = size_of(t);
    int          nb = (int'(ea[1:0]) + sz > 4) ? 2 : 1;
    bit          done = 0;
    logic [95:0] got_w, exp_w;
    log_addr.delete(); log_be.delete(); log_wd.delete();
    @(negedge clk);
    store = st; direccion = dir; offset = off; store_data = sd; Type = t; req_valid = 1'b1;
    stalls = 0;
    for (int c = 0; c < 200 && !done; c++) begin
      #1;
      if (stall) begin
        stalls++;
        @(negedge clk);
      end else done = 1;
    end
    if (!done) begin
      check_eq("done_timeout", 96'(0), 96'(1));
    end else if (!is_legal(t)) begin
      check_eq("illegal_flags", {err, load_valid}, 2'b10);
      check_eq("illegal_ld_zero", load_data, 32'h0);
      check_eq("illegal_no_beats", 96'(log_addr.size()), 96'(0));
      exp_ld = 32'h0;
    end else if (st) begin
      check_eq("st_flags", {err, load_valid}, 2'b00);
      check_eq("st_ld_hold", load_data, exp_ld);
      check_eq("st_beats", 96'(log_addr.size()), 96'(nb));
      for (int i = 0; i < sz; i++) exp_mem[ea + 32'(i)] = sd[8*i +: 8];
      for (int i = 0; i < 12; i++) begin
        got_w[8*i +: 8] = mem_rd(ea - 32'd4 + 32'(i));
        exp_w[8*i +: 8] = exp_rd(ea - 32'd4 + 32'(i));
      end
      check_eq("st_mem", got_w, exp_w);
    end else begin
      exp_ld = model_load(ea, t);
      check_eq("ld_flags", {err, load_valid}, 2'b01);
      check_eq("ld_data", load_data, exp_ld);
      check_eq("ld_beats", 96'(log_addr.size()), 96'(nb));
    end
    req_valid = 1'b0;
    @(negedge clk);
    #1 check_eq("after_done", {load_valid, err, stall}, 3'b000);
  endtask

  function automatic logic [67:0] beat(input int i);
    if (i >= log_addr.size()) return 68'h0;
    return {log_addr[i], log_be[i], log_wd[i]};
  endfunction

  int          cyc;
  logic [2:0]  legal_t[5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
  logic [2:0]  illegal_t[3] = '{3'b011, 3'b110, 3'b111};

  initial begin
    rst_n = 1'b0; req_valid = 1'b1; store = 1'b0; direccion = 32'h0; offset = 32'h0;
    store_data = 32'h0; Type = 3'b010;
    repeat (3) @(negedge clk);
    #1 check_eq("reset_outputs", {m_req, m_we, m_addr, m_be, m_wdata, load_valid, load_data,
                                  err, stall}, 96'h0);
    req_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // Aligned word store.
    run_txn(1'b1, 32'd0, 32'd4, 32'h0000000F, 3'b010, cyc);
    check_eq("sw_stalls", 96'(cyc), 96'(2));
    check_eq("sw_beat0", beat(0), {32'd4, 4'b1111, 32'h0000000F});

    // Byte loads, signed and unsigned.
    poke_word(32'd0, 32'h80000000);
    run_txn(1'b0, 32'd3, 32'd0, 32'h0, 3'b000, cyc);
    check_eq("lb_stalls", 96'(cyc), 96'(3));
    check_eq("lb_be", beat(0), {32'd0, 4'b1000, 32'h0});
    check_eq("lb_value", load_data, 32'hFFFFFF80);
    run_txn(1'b0, 32'd3, 32'd0, 32'h0, 3'b100, cyc);
    check_eq("lbu_value", load_data, 32'h00000080);

    // Misaligned word load across two words.
    poke_word(32'd4, 32'h11223344);
    poke_word(32'd8, 32'h55667788);
    run_txn(1'b0, 32'd2, 32'd4, 32'h0, 3'b010, cyc);
    check_eq("lw_split_beat0", beat(0), {32'd4, 4'b1100, 32'h0});
    check_eq("lw_split_beat1", beat(1), {32'd8, 4'b0011, 32'h0});
    check_eq("lw_split_value", load_data, 32'h77881122);

    // Misaligned half store.
    run_txn(1'b1, 32'd3, 32'd0, 32'h0000ABCD, 3'b001, cyc);
    check_eq("sh_split_beat0", beat(0), {32'd0, 4'b1000, 32'hCD0000AB});
    check_eq("sh_split_beat1", beat(1), {32'd4, 4'b0001, 32'hCD0000AB});
    check_eq("sh_ld_hold", load_data, 32'h77881122);

    // Back-pressure for three cycles on the first beat.
    hold_ready = 3;
    run_txn(1'b1, 32'd16, 32'd0, 32'hDEADBEEF, 3'b010, cyc);
    check_eq("hold_stalls", 96'(cyc), 96'(5));

    // Illegal Type after a load leaves load_data non-zero.
    run_txn(1'b0, 32'd8, 32'd0, 32'h0, 3'b010, cyc);
    run_txn(1'b0, 32'd8, 32'd0, 32'h0, 3'b011, cyc);
    check_eq("illegal_stalls", 96'(cyc), 96'(1));

    // Beat 1 address wraps past the top of the address space.
    run_txn(1'b0, 32'hFFFFFFFE, 32'd0, 32'h0, 3'b010, cyc);
    check_eq("wrap_beat1_addr", beat(1) >> 36, 96'h0);
    check_eq("wrap_beat0_addr", beat(0) >> 36, 96'hFFFFFFFC);

    // Reset while waiting for read data; the late response must be dropped.
    resp_off = 1;
    @(negedge clk);
    store = 1'b0; direccion = 32'h20; offset = 32'h0; Type = 3'b010; req_valid = 1'b1;
    repeat (2) @(negedge clk);
    #1 check_eq("rst_in_wait0", {stall, m_req}, 2'b10);
    #1 rst_n = 1'b0;
    #1 check_eq("rst_mid_outputs", {m_req, m_we, m_addr, m_be, m_wdata, load_valid, load_data,
                                    err, stall}, 96'h0);
    @(negedge clk);
    #2 rst_n = 1'b1; req_valid = 1'b0; resp_off = 0; force_rv = 1;
    exp_ld = 32'h0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1 force_rv = 0;
      check_eq("rst_late_rvalid", {load_valid, m_req, stall, err, load_data}, 96'h0);
    end

    // Randomized traffic.
    ready_pct = 70; rv_delay_max = 2; spur_en = 1;
    for (int n = 0; n < 150; n++) begin
      logic [31:0] d, o;
      logic [2:0]  t;
      d = ($urandom_range(1) == 0) ? 32'($urandom_range(60)) :
                                     32'hFFFFFFC0 + 32'($urandom_range(60));
      o = 32'($urandom_range(8)) - 32'd4;
      t = ($urandom_range(9) == 0) ? illegal_t[$urandom_range(2)] : legal_t[$urandom_range(4)];
      run_txn(1'($urandom_range(1)), d, o, $urandom, t, cyc);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got %0d of %0d checks", n_pass,
             n_chk);
    $fatal(1);
  end

endmodule
